cpu_sequencer: RTL and testbench

Program sequencer that feeds the 16-bit multi-cycle processor from a synchronous instruction ROM. It fetches instruction words, presents each one on the processor's DIN with a one-cycle Run pulse, and supplies the second word for move-immediate instructions. It then waits for Done before fetching the next word. It stops on a HALT opcode or on a Done timeout, and keeps a program counter and a retired-instruction count for the testbench and board LEDs.

---
 rtl/cpu_sequencer.sv | 133 +++++++++++++
 tb/tb_cpu_sequencer.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: program sequencer for the 16-bit multi-cycle processor.
// It fetches words from a synchronous ROM and issues each one with a single
// Run pulse. For mvi it also supplies the second word. It then waits for Done
// and stops on a HALT opcode or when Done does not arrive in time.
module cpu_sequencer #(
    parameter int ADDR_W  = 5,
    parameter int TIMEOUT = 8
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [15:0]       mem_data,
    output logic [15:0]       cpu_din,
    output logic              cpu_run,
    input  logic              cpu_done,
    output logic [ADDR_W-1:0] pc,
    output logic [15:0]       instr_count,
    output logic              Busy,
    output logic              Halted,
    output logic              Error
);

    // The counter only has to hold 0 .. TIMEOUT-1, which is the last wait
    // cycle in which Done is still accepted.
    localparam int TCNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_ISSUE,
        S_IMM,
        S_WAIT,
        S_HALT
    } state_t;

    state_t              state;
    logic [15:0]         instr;
    logic [TCNT_W-1:0]   tcnt;
    logic                imm_sel;

    // The ROM is addressed straight from the program counter. In ISSUE this
    // already points at the immediate word, so that word is on mem_data in IMM.
    assign mem_addr = pc;

    // Run and imm_sel are registered alongside the state. The immediate
    // arrives from the ROM only during IMM, so it is passed straight through.
    assign cpu_din = imm_sel ? mem_data : (cpu_run ? instr : 16'h0000);

    // Sequencer FSM: state, program counter, retirement count, timeout
    // counter and all registered status outputs.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state       <= S_IDLE;
            pc          <= '0;
            instr       <= '0;
            instr_count <= '0;
            tcnt        <= '0;
            imm_sel     <= 1'b0;
            cpu_run     <= 1'b0;
            Busy        <= 1'b0;
            Halted      <= 1'b0;
            Error       <= 1'b0;
        end else begin
            cpu_run <= 1'b0;
            imm_sel <= 1'b0;
            unique case (state)
                S_IDLE, S_HALT: begin
                    if (Start) begin
                        state       <= S_FETCH;
                        pc          <= '0;
                        instr_count <= '0;
                        Error       <= 1'b0;
                        Busy        <= 1'b1;
                        Halted      <= 1'b0;
                    end
                end
                S_FETCH: begin
                    state <= S_LOAD;
                end
                S_LOAD: begin
                    instr <= mem_data;
                    pc    <= pc + 1'b1;
                    if (mem_data[8:6] == OP_HALT) begin
                        state  <= S_HALT;
                        Busy   <= 1'b0;
                        Halted <= 1'b1;
                    end else begin
                        state   <= S_ISSUE;
                        cpu_run <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    tcnt <= '0;
                    if (instr[8:6] == OP_MVI) begin
                        state   <= S_IMM;
                        imm_sel <= 1'b1;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_IMM, S_WAIT: begin
                    if (state == S_IMM) begin
                        pc <= pc + 1'b1;
                    end
                    if (cpu_done) begin
                        instr_count <= instr_count + 16'd1;
                        state       <= S_FETCH;
                    end else if (tcnt == TCNT_LAST) begin
                        state  <= S_HALT;
                        Error  <= 1'b1;
                        Busy   <= 1'b0;
                        Halted <= 1'b1;
                    end else begin
                        state <= S_WAIT;
                        tcnt  <= tcnt + 1'b1;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    Busy   <= 1'b0;
                    Halted <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed and randomized bench for cpu_sequencer with a
// synchronous ROM, a processor stand-in answering Run after a chosen delay,
// and a program-level reference model.
module tb_cpu_sequencer;

    localparam int ADDR_W  = 5;
    localparam int TIMEOUT = 8;
    localparam int DEPTH   = 1 << ADDR_W;
    localparam logic [15:0] W_HALT = 16'h01C0;

    logic              clk = 1'b0;
    logic              Reset = 1'b1;
    logic              Start = 1'b0;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_data;
    logic [15:0]       cpu_din;
    logic              cpu_run;
    logic              cpu_done;
    logic [ADDR_W-1:0] pc;
    logic [15:0]       instr_count;
    logic              Busy;
    logic              Halted;
    logic              Error;

    int checks = 0;
    int errors = 0;

    cpu_sequencer #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .Clock       (clk),
        .Reset       (Reset),
        .Start       (Start),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .cpu_din     (cpu_din),
        .cpu_run     (cpu_run),
        .cpu_done    (cpu_done),
        .pc          (pc),
        .instr_count (instr_count),
        .Busy        (Busy),
        .Halted      (Halted),
        .Error       (Error)
    );

    always #5 clk = ~clk;

    // Synchronous instruction ROM: data appears one cycle after the address.
    logic [15:0] rom [DEPTH];
    always @(posedge clk) mem_data <= rom[mem_addr];

    // Processor stand-in: the n-th Run is answered with a one-cycle Done in
    // the delays[n]-th cycle after the Run cycle; 0 or missing means never.
    int   delays[$];
    int   issue_idx;
    int   done_cnt;
    logic done_extra = 1'b0;
    always @(posedge clk) begin
        if (Reset || (Start && !Busy)) begin
            issue_idx <= 0;
            done_cnt  <= 0;
        end else if (cpu_run) begin
            done_cnt  <= (issue_idx < delays.size()) ? delays[issue_idx] : 0;
            issue_idx <= issue_idx + 1;
        end else if (done_cnt > 0) begin
            done_cnt <= done_cnt - 1;
        end
    end
    assign cpu_done = (done_cnt == 1) || done_extra;

    // Bus monitor: logs issued words, immediates and Run cycle stamps, and
    // counts violations of the always-true output relationships.
    logic [15:0] obs_din[$];
    logic [15:0] obs_imm[$];
    int          obs_run_cyc[$];
    int          ncyc = 0;
    int          viol = 0;
    logic        prev_mvi = 1'b0;
    always @(negedge clk) begin
        ncyc++;
        if (Reset) begin
            prev_mvi = 1'b0;
        end else begin
            if (mem_addr !== pc) viol++;
            if (Busy && Halted) viol++;
            if (cpu_run && !Busy) viol++;
            if (Error && !Halted) viol++;
            if (prev_mvi) begin
                obs_imm.push_back(cpu_din);
            end else if (cpu_run) begin
                obs_din.push_back(cpu_din);
                obs_run_cyc.push_back(ncyc);
            end else if (cpu_din !== 16'h0000) begin
                viol++;
            end
            prev_mvi = cpu_run && (cpu_din[8:6] == 3'b001);
        end
    end

    // Program-level reference model: walks the ROM instruction by instruction
    // and computes the issued words, cycle of the Halted rise and final state.
    logic [15:0] exp_din[$];
    logic [15:0] exp_imm[$];
    int          exp_pc;
    int          exp_count;
    int          exp_halt_cyc;
    logic        exp_err;

    task automatic model_program();
        int p;
        int t;
        int k;
        int d;
        logic [15:0] w;
        p = 0;
        t = 1;
        k = 0;
        exp_din.delete();
        exp_imm.delete();
        exp_count    = 0;
        exp_err      = 1'b0;
        exp_halt_cyc = -1;
        for (int it = 0; it < 200; it++) begin
            w = rom[p];
            p = (p + 1) % DEPTH;
            if (w[8:6] == 3'b111) begin
                exp_halt_cyc = t + 2;
                break;
            end
            exp_din.push_back(w);
            if (w[8:6] == 3'b001) begin
                exp_imm.push_back(rom[p]);
                p = (p + 1) % DEPTH;
            end
            d = (k < delays.size()) ? delays[k] : 0;
            k++;
            if (d >= 1 && d <= TIMEOUT) begin
                exp_count++;
                t = t + 3 + d;
            end else begin
                exp_err      = 1'b1;
                exp_halt_cyc = t + 3 + TIMEOUT;
                break;
            end
        end
        exp_pc = p;
    endtask

    // Observations of one program run.
    logic [15:0]       act_din[$];
    logic [15:0]       act_imm[$];
    int                act_run_cyc[$];
    int                obs_halt;
    bit                obs_seen;
    logic              busy1;
    logic              err1;
    logic [ADDR_W-1:0] pc1;

    task automatic fill_rom(input logic [15:0] w);
        for (int a = 0; a < DEPTH; a++) rom[a] = w;
    endtask

    // Pulses Start and follows the run until Halted (bounded). Cycle 0 is
    // the cycle in which Start is sampled; done_extra is forced for cycles
    // below extra_until.
    task automatic launch(input int extra_until);
        int base_d;
        int base_i;
        int n;
        base_d = obs_din.size();
        base_i = obs_imm.size();
        @(negedge clk);
        Start      = 1'b1;
        done_extra = (extra_until > 0);
        n = 0;
        obs_seen = 0;
        while (n < 3000) begin
            @(negedge clk);
            n++;
            Start      = 1'b0;
            done_extra = (n < extra_until);
            if (n == 1) begin
                busy1 = Busy;
                err1  = Error;
                pc1   = pc;
            end
            if (Halted) begin
                obs_seen = 1;
                break;
            end
        end
        done_extra = 1'b0;
        obs_halt = n;
        act_din.delete();
        act_imm.delete();
        act_run_cyc.delete();
        for (int i = base_d; i < obs_din.size(); i++) begin
            act_din.push_back(obs_din[i]);
            act_run_cyc.push_back(obs_run_cyc[i]);
        end
        for (int i = base_i; i < obs_imm.size(); i++) act_imm.push_back(obs_imm[i]);
    endtask

    task automatic test_reset();
        fill_rom(W_HALT);
        delays.delete();
        repeat (3) @(negedge clk);
        Reset = 1'b0;
        @(negedge clk);
        checks++; if (pc !== '0 || mem_addr !== '0) begin errors++; $display("[TB] FAIL reset_pc: got pc=%0d addr=%0d, required 0", pc, mem_addr); end
        checks++; if (instr_count !== 16'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d, required 0", instr_count); end
        checks++; if ({Busy, Halted, Error} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags: got %b, required 000", {Busy, Halted, Error}); end
        checks++; if (cpu_run !== 1'b0 || cpu_din !== 16'h0000) begin errors++; $display("[TB] FAIL reset_cpu: got run=%b din=%h, required 0/0000", cpu_run, cpu_din); end
    endtask

    task automatic test_mv_halt();
        fill_rom(W_HALT);
        rom[0] = 16'h0000;
        delays = '{1};
        launch(0);
        checks++; if (busy1 !== 1'b1) begin errors++; $display("[TB] FAIL mv_busy: got %b, required 1", busy1); end
        checks++; if (!obs_seen || obs_halt != 7) begin errors++; $display("[TB] FAIL mv_halt_cycle: got %0d, required 7", obs_halt); end
        checks++; if (pc !== 5'd2 || instr_count !== 16'd1) begin errors++; $display("[TB] FAIL mv_state: got pc=%0d count=%0d, required 2/1", pc, instr_count); end
        checks++; if (act_din.size() != 1 || act_din[0] !== 16'h0000) begin errors++; $display("[TB] FAIL mv_issue: got %0d runs first=%h, required 1 run 0000", act_din.size(), act_din[0]); end
    endtask

    task automatic test_mvi();
        fill_rom(W_HALT);
        rom[0] = 16'h0040;
        rom[1] = 16'h1234;
        delays = '{1};
        launch(0);
        checks++; if (act_din.size() != 1 || act_din[0] !== 16'h0040) begin errors++; $display("[TB] FAIL mvi_issue: got %0d runs first=%h, required 1 run 0040", act_din.size(), act_din[0]); end
        checks++; if (act_imm.size() != 1 || act_imm[0] !== 16'h1234) begin errors++; $display("[TB] FAIL mvi_imm: got %0d imms first=%h, required 1234", act_imm.size(), act_imm[0]); end
        checks++; if (pc !== 5'd3 || instr_count !== 16'd1 || obs_halt != 7) begin errors++; $display("[TB] FAIL mvi_state: got pc=%0d count=%0d halt=%0d, required 3/1/7", pc, instr_count, obs_halt); end
    endtask

    task automatic test_add_timing();
        fill_rom(W_HALT);
        rom[0] = 16'h0080;
        rom[1] = 16'h0000;
        delays = '{3, 1};
        launch(0);
        checks++; if (act_run_cyc.size() != 2 || act_run_cyc[1] - act_run_cyc[0] != 6) begin errors++; $display("[TB] FAIL add_spacing: got %0d runs gap=%0d, required 2 runs gap 6", act_run_cyc.size(), act_run_cyc[1] - act_run_cyc[0]); end
        checks++; if (Error !== 1'b0 || instr_count !== 16'd2 || obs_halt != 13) begin errors++; $display("[TB] FAIL add_state: got err=%b count=%0d halt=%0d, required 0/2/13", Error, instr_count, obs_halt); end
    endtask

    task automatic test_ignored_done();
        fill_rom(W_HALT);
        rom[0] = 16'h0000;
        delays = '{1};
        launch(4);
        checks++; if (instr_count !== 16'd1 || obs_halt != 7) begin errors++; $display("[TB] FAIL ignored_done: got count=%0d halt=%0d, required 1/7", instr_count, obs_halt); end
    endtask

    task automatic test_timeout();
        fill_rom(W_HALT);
        rom[0] = 16'h0000;
        delays.delete();
        launch(0);
        checks++; if (!obs_seen || obs_halt != 3 + TIMEOUT + 1) begin errors++; $display("[TB] FAIL timeout_cycle: got %0d, required %0d", obs_halt, 3 + TIMEOUT + 1); end
        checks++; if (Error !== 1'b1 || pc !== 5'd1 || instr_count !== 16'd0) begin errors++; $display("[TB] FAIL timeout_state: got err=%b pc=%0d count=%0d, required 1/1/0", Error, pc, instr_count); end
        delays = '{1};
        launch(0);
        checks++; if (err1 !== 1'b0 || pc1 !== '0) begin errors++; $display("[TB] FAIL timeout_restart: got err=%b pc=%0d, required 0/0", err1, pc1); end
        checks++; if (Error !== 1'b0 || instr_count !== 16'd1) begin errors++; $display("[TB] FAIL timeout_rerun: got err=%b count=%0d, required 0/1", Error, instr_count); end
    endtask

    task automatic test_timeout_boundary();
        fill_rom(W_HALT);
        rom[0] = 16'h00C0;
        delays = '{TIMEOUT};
        launch(0);
        checks++; if (Error !== 1'b0 || instr_count !== 16'd1 || obs_halt != 1 + 3 + TIMEOUT + 2) begin errors++; $display("[TB] FAIL edge_done: got err=%b count=%0d halt=%0d, required 0/1/%0d", Error, instr_count, obs_halt, 1 + 3 + TIMEOUT + 2); end
        delays = '{TIMEOUT + 1};
        launch(0);
        checks++; if (Error !== 1'b1 || instr_count !== 16'd0 || obs_halt != 3 + TIMEOUT + 1) begin errors++; $display("[TB] FAIL edge_late: got err=%b count=%0d halt=%0d, required 1/0/%0d", Error, instr_count, obs_halt, 3 + TIMEOUT + 1); end
    endtask

    task automatic test_wrap();
        fill_rom(16'h0000);
        rom[0]         = 16'h00AA;
        rom[DEPTH - 1] = 16'h0040;
        delays.delete();
        for (int i = 0; i < DEPTH - 1; i++) delays.push_back(1);
        launch(0);
        checks++; if (act_imm.size() != 1 || act_imm[0] !== 16'h00AA) begin errors++; $display("[TB] FAIL wrap_imm: got %0d imms first=%h, required 00AA", act_imm.size(), act_imm[0]); end
        checks++; if (pc !== 5'd1 || Error !== 1'b1 || instr_count !== 16'(DEPTH - 1)) begin errors++; $display("[TB] FAIL wrap_state: got pc=%0d err=%b count=%0d, required 1/1/%0d", pc, Error, instr_count, DEPTH - 1); end
        checks++; if (obs_halt != 1 + 4 * (DEPTH - 1) + 3 + TIMEOUT) begin errors++; $display("[TB] FAIL wrap_cycle: got %0d, required %0d", obs_halt, 1 + 4 * (DEPTH - 1) + 3 + TIMEOUT); end
    endtask

    task automatic test_reset_mid();
        fill_rom(W_HALT);
        rom[0] = 16'h0000;
        delays.delete();
        @(negedge clk); Start = 1'b1;
        @(negedge clk); Start = 1'b0;
        repeat (3) @(negedge clk);
        Start = 1'b1;
        @(negedge clk);
        checks++; if (pc !== 5'd1 || Busy !== 1'b1) begin errors++; $display("[TB] FAIL start_in_wait: got pc=%0d busy=%b, required 1/1", pc, Busy); end
        Reset = 1'b1;
        @(negedge clk);
        checks++; if ({pc, instr_count, Busy, Halted, Error, cpu_run} !== '0 || cpu_din !== 16'h0000 || mem_addr !== '0) begin errors++; $display("[TB] FAIL reset_in_wait: got pc=%0d count=%0d flags=%b%b%b run=%b din=%h, required all 0", pc, instr_count, Busy, Halted, Error, cpu_run, cpu_din); end
        Reset = 1'b0;
        Start = 1'b0;
        @(negedge clk);
        Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        @(negedge clk);
        Reset = 1'b1;
        @(negedge clk);
        checks++; if (cpu_run !== 1'b0 || Busy !== 1'b0 || instr_count !== 16'd0) begin errors++; $display("[TB] FAIL reset_in_load: got run=%b busy=%b count=%0d, required 0/0/0", cpu_run, Busy, instr_count); end
        Reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int r = 0; r < 12; r++) begin
            int len;
            bit bad;
            logic [15:0] w;
            len = $urandom_range(1, 20);
            fill_rom(W_HALT);
            for (int a = 0; a < len; a++) begin
                w = 16'($urandom);
                w[8:6] = 3'($urandom_range(0, 6));
                rom[a] = w;
            end
            delays.delete();
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 7) == 0) delays.push_back(($urandom_range(0, 1) == 0) ? 0 : TIMEOUT + int'($urandom_range(1, 3)));
                else delays.push_back(int'($urandom_range(1, TIMEOUT)));
            end
            model_program();
            launch(0);
            checks++; if (!obs_seen || obs_halt != exp_halt_cyc) begin errors++; $display("[TB] FAIL rand%0d halt_cycle: got %0d, required %0d", r, obs_halt, exp_halt_cyc); end
            checks++; if (pc !== ADDR_W'(exp_pc) || instr_count !== 16'(exp_count) || Error !== exp_err) begin errors++; $display("[TB] FAIL rand%0d state: got pc=%0d count=%0d err=%b, required %0d/%0d/%b", r, pc, instr_count, Error, exp_pc, exp_count, exp_err); end
            bad = 0;
            if (act_din.size() != exp_din.size()) bad = 1;
            else foreach (exp_din[i]) if (act_din[i] !== exp_din[i]) bad = 1;
            checks++; if (bad) begin errors++; $display("[TB] FAIL rand%0d issue_seq: got %0d words, required %0d", r, act_din.size(), exp_din.size()); end
            bad = 0;
            if (act_imm.size() != exp_imm.size()) bad = 1;
            else foreach (exp_imm[i]) if (act_imm[i] !== exp_imm[i]) bad = 1;
            checks++; if (bad) begin errors++; $display("[TB] FAIL rand%0d imm_seq: got %0d words, required %0d", r, act_imm.size(), exp_imm.size()); end
        end
    endtask

    task automatic test_invariants();
        checks++; if (viol != 0) begin errors++; $display("[TB] FAIL bus_invariants: got %0d violations, required 0", viol); end
    endtask

    // Hang guard: a run that never finishes is reported and stopped.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, required finish before time 500000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_mv_halt();
        test_mvi();
        test_add_timing();
        test_ignored_done();
        test_timeout();
        test_timeout_boundary();
        test_wrap();
        test_reset_mid();
        test_random();
        test_invariants();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
